cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  - Shares the single physical memory port between icache and dcache line-fill/writeback traffic.
//  - Sits below both caches, between the caches' pmem sides and main memory/L2.
//  - Grants one requester per transaction, latches its command, and routes mem_resp/rdata back to the granted cache only.
// PARAMETERS
//  LINE_WIDTH  256  cache line / memory data width in bits
//  ADDR_WIDTH  32   line address width in bits
// PORTS
//  clk             in   1           clock; all state updates on rising edge
//  rst             in   1           synchronous, active-high reset
//  i_pmem_read     in   1           icache line read request; held until i_pmem_resp
//  i_pmem_addr     in   ADDR_WIDTH  icache line address
//  i_pmem_rdata    out  LINE_WIDTH  line data to icache; valid when i_pmem_resp=1
//  i_pmem_resp     out  1           icache transaction done (1-cycle pulse)
//  d_pmem_read     in   1           dcache line read request; held until d_pmem_resp
//  d_pmem_write    in   1           dcache line writeback request; held until d_pmem_resp
//  d_pmem_addr     in   ADDR_WIDTH  dcache line address
//  d_pmem_wdata    in   LINE_WIDTH  dcache writeback data
//  d_pmem_rdata    out  LINE_WIDTH  line data to dcache; valid when d_pmem_resp=1
//  d_pmem_resp     out  1           dcache transaction done (1-cycle pulse)
//  mem_read        out  1           memory read command
//  mem_write       out  1           memory write command
//  mem_addr        out  ADDR_WIDTH  memory line address (latched at grant)
//  mem_wdata       out  LINE_WIDTH  memory write data (latched at grant)
//  mem_rdata       in   LINE_WIDTH  memory read data; valid with mem_resp
//  mem_resp        in   1           memory transaction done (1-cycle pulse)
// BEHAVIOUR
//  - FSM states: IDLE, SERVE_I, SERVE_D; reset -> IDLE.
//  - IDLE: no mem command. If any request is pending, the FSM picks a winner (see CONFIGURATION).
//    It latches addr, wdata and op (read/write) into cmd regs and moves to SERVE_I or SERVE_D.
//  - SERVE_x: mem_read/mem_write/mem_addr/mem_wdata are driven from the cmd regs, not from live inputs.
//    Requester input changes during service are ignored.
//  - Latency: request visible in IDLE at edge N -> mem command asserted from cycle N+1.
//  - Response: when mem_resp=1 in SERVE_x, x_pmem_resp=1 in the same cycle and x_pmem_rdata=mem_rdata.
//    Next state is IDLE. The other cache's resp stays 0.
//  - Mandatory 1-cycle IDLE gap after every mem_resp: mem_read=mem_write=0 for at least one cycle between transactions.
//  - i_pmem_rdata/d_pmem_rdata: combinational pass-through of mem_rdata (don't-care when resp=0).
//  - mem_resp while in IDLE: ignored; no resp is forwarded.
//  - A request dropped before resp is a protocol violation; the latched transaction still completes to memory.
//  - d_pmem_read and d_pmem_write both 1: illegal; sim assertion fires; write wins.
//  - Reset values: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, i_pmem_resp=0, d_pmem_resp=0, cmd regs=0, rr_last=0.
//  - rst mid-transaction: FSM -> IDLE next cycle and the transaction is abandoned.
//    Memory and caches are reset by the same rst.
//  - No resp outputs are combinationally dependent on requester inputs (only on state + mem_resp).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN
//  - Undefined (default): fixed priority; dcache beats icache on simultaneous requests in IDLE.
//  - Defined: 1-bit reg rr_last records the last-granted requester (0=I, 1=D).
//    On a tie, the requester that was not last granted wins. A lone requester always wins.
//    rr_last updates on every grant.
// TESTING
//  1. i_pmem_read=1, i_pmem_addr=0x0000_0060; mem_resp 4 cycles later with mem_rdata=256'hAB..AB
//     -> mem_read=1, mem_addr=0x60 from next cycle; i_pmem_resp=1 with rdata=AB..AB; d_pmem_resp=0;
//     -> mem_read=0 on the following cycle.
//  2. i read 0x100 and d write 0x200 (wdata=256'h1234) asserted together, macro off
//     -> mem_write, addr 0x200, wdata 0x1234 first; after d_pmem_resp and 1 IDLE cycle, mem_read addr 0x100.
//  3. Macro on; both caches request continuously for 4 transactions
//     -> grants alternate D,I,D,I (rr_last=0 at reset); each resp goes only to its owner.
//  4. d read 0x40 granted; i_pmem_addr and d_pmem_addr changed mid-service
//     -> mem_addr stays 0x40 until mem_resp.
//  5. rst=1 while SERVE_D with mem_write=1
//     -> next cycle mem_write=0, all resps=0, FSM IDLE; a stale mem_resp after rst is not forwarded.
//  6. d_pmem_read=d_pmem_write=1
//     -> assertion fires and a write transaction is issued.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Brief    : Shares one physical memory port between icache and dcache
//            line-fill / writeback traffic. One requester is granted per
//            transaction. Its command is latched at grant, and the memory
//            response is routed back to the granted cache only.
//            Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break.
//            When the macro is undefined, dcache has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_addr,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_addr,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [LINE_WIDTH-1:0] r_cmd_wdata;
  logic                  r_cmd_read;
  logic                  r_cmd_write;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;
  logic w_grant;

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  // Last-granted requester: 0 = icache, 1 = dcache.
  logic r_rr_last;

  // On a tie the requester that was not served last wins.
  assign w_grant_d = w_d_req & (~w_i_req | ~r_rr_last);

  // Remember who was granted on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last <= 1'b0;
    end else if (r_state == ST_IDLE && w_grant) begin
      r_rr_last <= w_grant_d;
    end
  end
`else
  // Fixed priority: dcache beats icache.
  assign w_grant_d = w_d_req;
`endif

  assign w_grant_i = w_i_req & ~w_grant_d;
  assign w_grant   = w_grant_i | w_grant_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE on memory response.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_next_state = ST_SERVE_D;
        end else if (w_grant_i) begin
          w_next_state = ST_SERVE_I;
        end
      end
      ST_SERVE_I,
      ST_SERVE_D: begin
        if (mem_resp) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Latch the winner's command at grant so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_read  <= 1'b0;
      r_cmd_write <= 1'b0;
    end else if (r_state == ST_IDLE && w_grant) begin
      // A simultaneous dcache read+write is treated as a write.
      r_cmd_addr  <= w_grant_d ? d_pmem_addr  : i_pmem_addr;
      r_cmd_wdata <= w_grant_d ? d_pmem_wdata : '0;
      r_cmd_write <= w_grant_d & d_pmem_write;
      r_cmd_read  <= w_grant_i | (w_grant_d & ~d_pmem_write);
    end
  end

  // Output logic: memory command only while serving, resp to the owner only.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = r_cmd_addr;
    mem_wdata   = r_cmd_wdata;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (r_state)
      ST_SERVE_I: begin
        mem_read    = r_cmd_read;
        mem_write   = r_cmd_write;
        i_pmem_resp = mem_resp;
      end
      ST_SERVE_D: begin
        mem_read    = r_cmd_read;
        mem_write   = r_cmd_write;
        d_pmem_resp = mem_resp;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

`ifndef SYNTHESIS
  // Flag the illegal simultaneous dcache read and write request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(d_pmem_read && d_pmem_write))
        else $warning("cache_mem_arbiter: d_pmem_read and d_pmem_write both set, write wins");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_arbiter
// Brief    : Directed self-checking bench for cache_mem_arbiter. The bench
//            plays the role of the caches and of main memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_addr;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_addr;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  int tests_run    = 0;
  int tests_failed = 0;

  cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pmem_read  (i_pmem_read),
    .i_pmem_addr  (i_pmem_addr),
    .i_pmem_rdata (i_pmem_rdata),
    .i_pmem_resp  (i_pmem_resp),
    .d_pmem_read  (d_pmem_read),
    .d_pmem_write (d_pmem_write),
    .d_pmem_addr  (d_pmem_addr),
    .d_pmem_wdata (d_pmem_wdata),
    .d_pmem_rdata (d_pmem_rdata),
    .d_pmem_resp  (d_pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_pmem_read  = 1'b0;
    i_pmem_addr  = '0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    d_pmem_addr  = '0;
    d_pmem_wdata = '0;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    tests_run++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cmd: read=%b write=%b, expected 0 0", mem_read, mem_write);
    end
    tests_run++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_addr_wdata: addr=%h wdata=%h, expected 0", mem_addr, mem_wdata);
    end
    tests_run++;
    if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_resp: i=%b d=%b, expected 0 0", i_pmem_resp, d_pmem_resp);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_icache_read();
    logic [LW-1:0] ab;
    ab = {32{8'hAB}};
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h0000_0060;
    tick();
    tests_run++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h60) begin
      tests_failed++;
      $display("FAIL icache_cmd: read=%b write=%b addr=%h, expected 1 0 60", mem_read, mem_write, mem_addr);
    end
    tick();
    tick();
    tick();
    mem_resp  = 1'b1;
    mem_rdata = ab;
    #1;
    tests_run++;
    if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== ab) begin
      tests_failed++;
      $display("FAIL icache_resp: resp=%b rdata=%h, expected 1 %h", i_pmem_resp, i_pmem_rdata, ab);
    end
    tests_run++;
    if (d_pmem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL icache_resp_other: d_resp=%b, expected 0", d_pmem_resp);
    end
    tick();
    mem_resp    = 1'b0;
    i_pmem_read = 1'b0;
    #1;
    tests_run++;
    if (mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL icache_gap: mem_read=%b, expected 0", mem_read);
    end
    tick();
  endtask

  task automatic test_priority();
    i_pmem_read  = 1'b1;
    i_pmem_addr  = 32'h100;
    d_pmem_write = 1'b1;
    d_pmem_addr  = 32'h200;
    d_pmem_wdata = 256'h1234;
    tick();
    tests_run++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h200 || mem_wdata !== 256'h1234) begin
      tests_failed++;
      $display("FAIL prio_first: write=%b read=%b addr=%h wdata=%h, expected 1 0 200 1234",
               mem_write, mem_read, mem_addr, mem_wdata);
    end
    tick();
    mem_resp = 1'b1;
    #1;
    tests_run++;
    if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_resp_d: d=%b i=%b, expected 1 0", d_pmem_resp, i_pmem_resp);
    end
    tick();
    mem_resp     = 1'b0;
    d_pmem_write = 1'b0;
    #1;
    tests_run++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_gap: read=%b write=%b, expected 0 0", mem_read, mem_write);
    end
    tick();
    tests_run++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL prio_second: read=%b write=%b addr=%h, expected 1 0 100", mem_read, mem_write, mem_addr);
    end
    mem_resp = 1'b1;
    #1;
    tests_run++;
    if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_resp_i: i=%b d=%b, expected 1 0", i_pmem_resp, d_pmem_resp);
    end
    tick();
    mem_resp    = 1'b0;
    i_pmem_read = 1'b0;
    tick();
  endtask

  // Both caches request continuously; expected owner sequence depends on build.
  task automatic test_back_to_back();
    logic exp_d;
    logic last_d;
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h300;
    d_pmem_read = 1'b1;
    d_pmem_addr = 32'h400;
    last_d = 1'b0;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d  = ~last_d;
`else
      exp_d  = 1'b1;
`endif
      last_d = exp_d;
      tick();
      tests_run++;
      if (mem_read !== 1'b1 || mem_addr !== (exp_d ? 32'h400 : 32'h300)) begin
        tests_failed++;
        $display("FAIL b2b_grant%0d: read=%b addr=%h, expected 1 %h", t, mem_read, mem_addr,
                 exp_d ? 32'h400 : 32'h300);
      end
      mem_resp  = 1'b1;
      mem_rdata = {8{t[31:0] + 32'hC0DE_0000}};
      #1;
      tests_run++;
      if (d_pmem_resp !== exp_d || i_pmem_resp !== ~exp_d) begin
        tests_failed++;
        $display("FAIL b2b_resp%0d: d=%b i=%b, expected %b %b", t, d_pmem_resp, i_pmem_resp, exp_d, ~exp_d);
      end
      tick();
      mem_resp = 1'b0;
      #1;
      tests_run++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_gap%0d: read=%b write=%b, expected 0 0", t, mem_read, mem_write);
      end
    end
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_input_ignored();
    d_pmem_read = 1'b1;
    d_pmem_addr = 32'h40;
    tick();
    tests_run++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h40) begin
      tests_failed++;
      $display("FAIL hold_grant: read=%b addr=%h, expected 1 40", mem_read, mem_addr);
    end
    d_pmem_addr = 32'hFFF0;
    i_pmem_addr = 32'hEEE0;
    tick();
    tests_run++;
    if (mem_addr !== 32'h40) begin
      tests_failed++;
      $display("FAIL hold_mid: addr=%h, expected 40", mem_addr);
    end
    mem_resp = 1'b1;
    #1;
    tests_run++;
    if (mem_addr !== 32'h40 || d_pmem_resp !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_resp: addr=%h d_resp=%b, expected 40 1", mem_addr, d_pmem_resp);
    end
    tick();
    mem_resp    = 1'b0;
    d_pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_pmem_write = 1'b1;
    d_pmem_addr  = 32'h80;
    d_pmem_wdata = 256'h5555;
    tick();
    tests_run++;
    if (mem_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pre: write=%b, expected 1", mem_write);
    end
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_post: write=%b read=%b i=%b d=%b, expected 0 0 0 0",
               mem_write, mem_read, i_pmem_resp, d_pmem_resp);
    end
    mem_resp = 1'b1;
    #1;
    tests_run++;
    if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_resp: i=%b d=%b, expected 0 0", i_pmem_resp, d_pmem_resp);
    end
    tick();
    mem_resp = 1'b0;
    #1;
    tests_run++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_idle: read=%b write=%b, expected 0 0", mem_read, mem_write);
    end
    tick();
  endtask

  task automatic test_read_write_conflict();
    d_pmem_read  = 1'b1;
    d_pmem_write = 1'b1;
    d_pmem_addr  = 32'h500;
    d_pmem_wdata = 256'h9ABC;
    tick();
    d_pmem_read = 1'b0;
    #1;
    tests_run++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h500 || mem_wdata !== 256'h9ABC) begin
      tests_failed++;
      $display("FAIL conflict_write: write=%b read=%b addr=%h wdata=%h, expected 1 0 500 9abc",
               mem_write, mem_read, mem_addr, mem_wdata);
    end
    mem_resp = 1'b1;
    #1;
    tests_run++;
    if (d_pmem_resp !== 1'b1) begin
      tests_failed++;
      $display("FAIL conflict_resp: d_resp=%b, expected 1", d_pmem_resp);
    end
    tick();
    mem_resp     = 1'b0;
    d_pmem_write = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_priority();
    test_back_to_back();
    test_input_ignored();
    test_reset_mid();
    test_read_write_conflict();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
